// File: rtl/qtree_pair_sequencer_pkg.sv
// Shared types for the masked-add input sequencer: the QTree token layout,
// its width, and the tree-select state used by the sequencer FSM.
package qtree_pair_sequencer_pkg;

  // One QTree token as seen by the masked-add stage.
  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] value;
  } QTree_Int_t;

  localparam int QTREE_TOKEN_W = $bits(QTree_Int_t);

  // Which operand tree is currently being forwarded downstream.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } tree_sel_t;

  // The tree that follows the given one in the A, B, A, B ... sequence.
  function automatic tree_sel_t next_tree(input tree_sel_t cur);
    return (cur == SEL_A) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/qtree_pair_sequencer_if.sv
// AXI-stream style token link used for both operand inputs and the
// sequenced output. tuser carries the source tree on the output side.
interface qtree_pair_sequencer_if #(
  parameter int W = 67
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tuser;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tlast,
    output tuser,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tuser,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/qtree_stream_fifo.sv
// Synchronous FIFO for one operand stream. full and empty are registered so
// that the input tready is a clean flop output; the head entry is read
// straight out of the storage registers.
module qtree_stream_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          full;
  logic          push;
  logic          pop;

  // A write is only admitted against the registered full flag, so a read in
  // the same cycle on a full FIFO does not make room for it.
  assign push     = wr_valid && !full;
  assign pop      = rd_en && !empty;
  assign wr_ready = !full;
  assign rd_data  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // Token storage; contents need no reset because empty guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/qtree_pair_sequencer.sv
// Feeds the masked-add stage: buffers operand trees A and B independently
// and forwards all of tree A (through its tlast), then all of tree B, then
// the next pair. Tokens pass through untouched; tuser marks the source.
module qtree_pair_sequencer
  import qtree_pair_sequencer_pkg::*;
#(
  parameter int TOKEN_W = QTREE_TOKEN_W,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  qtree_pair_sequencer_if.slave  s_a,
  qtree_pair_sequencer_if.slave  s_b,
  qtree_pair_sequencer_if.master m,
  output logic                   pair_done,
  output logic [CNT_W-1:0]       pair_count
);

  // FIFO entries hold {tlast, tdata}.
  logic [TOKEN_W:0]   a_head;
  logic [TOKEN_W:0]   b_head;
  logic [TOKEN_W:0]   sel_head;
  logic               a_empty;
  logic               b_empty;
  logic               a_ready;
  logic               b_ready;
  logic               sel_empty;
  logic               load_en;
  logic               pop;
  logic               pop_a;
  logic               pop_b;
  logic               b_last_accepted;

  tree_sel_t          sel;
  logic [TOKEN_W-1:0] m_data;
  logic               m_last;
  logic               m_user;
  logic               m_valid;

  qtree_stream_fifo #(
    .DEPTH (DEPTH),
    .W     (TOKEN_W + 1)
  ) u_fifo_a (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_data  ({s_a.tlast, s_a.tdata}),
    .wr_valid (s_a.tvalid),
    .wr_ready (a_ready),
    .rd_en    (pop_a),
    .rd_data  (a_head),
    .empty    (a_empty)
  );

  qtree_stream_fifo #(
    .DEPTH (DEPTH),
    .W     (TOKEN_W + 1)
  ) u_fifo_b (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_data  ({s_b.tlast, s_b.tdata}),
    .wr_valid (s_b.tvalid),
    .wr_ready (b_ready),
    .rd_en    (pop_b),
    .rd_data  (b_head),
    .empty    (b_empty)
  );

  assign s_a.tready = a_ready;
  assign s_b.tready = b_ready;

  // Only the FIFO of the tree in progress is ever read; the other one just
  // fills (and back-pressures) until its turn comes.
  assign load_en   = !m_valid || m.tready;
  assign sel_empty = (sel == SEL_A) ? a_empty : b_empty;
  assign sel_head  = (sel == SEL_A) ? a_head  : b_head;
  assign pop       = load_en && !sel_empty;
  assign pop_a     = pop && (sel == SEL_A);
  assign pop_b     = pop && (sel == SEL_B);

  // Tree-select FSM and output register slice; m_* hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sel     <= SEL_A;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end else if (load_en) begin
      if (!sel_empty) begin
        m_data  <= sel_head[TOKEN_W-1:0];
        m_last  <= sel_head[TOKEN_W];
        m_user  <= (sel == SEL_B);
        m_valid <= 1'b1;
        if (sel_head[TOKEN_W]) begin
          sel <= next_tree(sel);
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m.tdata  = m_data;
  assign m.tlast  = m_last;
  assign m.tuser  = m_user;
  assign m.tvalid = m_valid;

  // A pair is complete when the last token of tree B leaves downstream.
  assign b_last_accepted = m_valid && m.tready && m_last && m_user;

  // Pair-completion pulse and wrapping pair counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pair_done  <= 1'b0;
      pair_count <= '0;
    end else begin
      pair_done <= b_last_accepted;
      if (b_last_accepted) begin
        pair_count <= pair_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qtree_pair_sequencer.sv
// Directed bench for qtree_pair_sequencer: queued A/B trees, a scoreboard
// of the expected sequenced stream, and per-cycle pair_done/count checks.
module tb_qtree_pair_sequencer;
  import qtree_pair_sequencer_pkg::*;

  localparam int TOKEN_W = QTREE_TOKEN_W;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  qtree_pair_sequencer_if #(.W(TOKEN_W)) s_a ();
  qtree_pair_sequencer_if #(.W(TOKEN_W)) s_b ();
  qtree_pair_sequencer_if #(.W(TOKEN_W)) m ();
  logic             pair_done;
  logic [CNT_W-1:0] pair_count;

  qtree_pair_sequencer #(
    .TOKEN_W (TOKEN_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_a        (s_a),
    .s_b        (s_b),
    .m          (m),
    .pair_done  (pair_done),
    .pair_count (pair_count)
  );

  logic [TOKEN_W:0]   a_src[$];
  logic [TOKEN_W:0]   b_src[$];
  logic [TOKEN_W+1:0] exp_q[$];
  logic [TOKEN_W+1:0] stall_val;
  logic [CNT_W-1:0]   exp_cnt;
  bit a_en, b_en, rand_rdy, a_pend, b_pend, stall_pend, done_pend;
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [TOKEN_W-1:0] tok(input int tree, input int idx);
    return {3'(idx % 8), 32'(32'hA000_0000 + tree), 32'(idx)};
  endfunction

  // Queue one A/B pair on the inputs and its expected sequenced output.
  task automatic add_pair(input int tree, input int na, input int nb);
    for (int i = 0; i < na; i++) begin
      a_src.push_back({1'(i == na - 1), tok(2 * tree, i)});
      exp_q.push_back({1'b0, 1'(i == na - 1), tok(2 * tree, i)});
    end
    for (int i = 0; i < nb; i++) begin
      b_src.push_back({1'(i == nb - 1), tok(2 * tree + 1, i)});
      exp_q.push_back({1'b1, 1'(i == nb - 1), tok(2 * tree + 1, i)});
    end
  endtask

  // One clock: commit last edge's handshakes, check, then drive and observe.
  task automatic step();
    logic [TOKEN_W+1:0] got;
    logic [TOKEN_W+1:0] want;
    @(negedge aclk);
    if (a_pend) void'(a_src.pop_front());
    if (b_pend) void'(b_src.pop_front());
    if (stall_pend)
      check_eq("stall_hold", {m.tvalid, m.tuser, m.tlast, m.tdata}, {1'b1, stall_val});
    check_eq("pair_done", pair_done, done_pend);
    if (done_pend) check_eq("pair_count", pair_count, exp_cnt);
    if (a_en && a_src.size() > 0) begin
      s_a.tvalid = 1'b1;
      {s_a.tlast, s_a.tdata} = a_src[0];
    end else s_a.tvalid = 1'b0;
    if (b_en && b_src.size() > 0) begin
      s_b.tvalid = 1'b1;
      {s_b.tlast, s_b.tdata} = b_src[0];
    end else s_b.tvalid = 1'b0;
    m.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    a_pend = s_a.tvalid && s_a.tready;
    b_pend = s_b.tvalid && s_b.tready;
    got = {m.tuser, m.tlast, m.tdata};
    done_pend = 1'b0;
    if (m.tvalid && m.tready) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check_eq("token", got, want);
      if (m.tlast && m.tuser) begin
        done_pend = 1'b1;
        exp_cnt = exp_cnt + 1'b1;
      end
    end
    stall_pend = m.tvalid && !m.tready;
    stall_val = got;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || a_src.size() > 0 || b_src.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drained", exp_q.size(), 0);
    step();
    step();
  endtask

  // Asynchronous reset for one clock, starting at the current time.
  task automatic apply_reset();
    aresetn = 1'b0;
    s_a.tvalid = 1'b0;
    s_b.tvalid = 1'b0;
    a_src.delete();
    b_src.delete();
    exp_q.delete();
    a_pend = 0; b_pend = 0; stall_pend = 0; done_pend = 0;
    exp_cnt = '0;
    #1;
    check_eq("rst_tvalid", m.tvalid, 1'b0);
    check_eq("rst_count", pair_count, '0);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    s_a.tvalid = 0; s_a.tlast = 0; s_a.tuser = 0; s_a.tdata = '0;
    s_b.tvalid = 0; s_b.tlast = 0; s_b.tuser = 0; s_b.tdata = '0;
    m.tready = 1'b0;
    exp_cnt = '0;
    a_en = 0; b_en = 0; rand_rdy = 0;
    a_pend = 0; b_pend = 0; stall_pend = 0; done_pend = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    check_eq("reset_tvalid", m.tvalid, 1'b0);
    check_eq("reset_tdata", m.tdata, '0);
    check_eq("reset_tlast", m.tlast, 1'b0);
    check_eq("reset_tuser", m.tuser, 1'b0);
    check_eq("reset_pair_done", pair_done, 1'b0);
    check_eq("reset_pair_count", pair_count, '0);
    check_eq("reset_a_tready", s_a.tready, 1'b1);
    check_eq("reset_b_tready", s_b.tready, 1'b1);

    // Basic pair A=3, B=2 with first-token latency.
    a_en = 1; b_en = 1;
    add_pair(0, 3, 2);
    step();
    step();
    check_eq("latency_edge_n", m.tvalid, 1'b0);
    step();
    check_eq("latency_edge_n1", m.tvalid, 1'b1);
    run(100);
    check_eq("t1_pair_count", pair_count, 2'd1);

    // Tree B arrives first and overfills its FIFO; A then goes first.
    a_en = 0; b_en = 1;
    add_pair(1, 3, 6);
    repeat (10) step();
    check_eq("t2_b_backpressure", s_b.tready, 1'b0);
    check_eq("t2_b_accepted", b_src.size(), 2);
    check_eq("t2_no_output", m.tvalid, 1'b0);
    a_en = 1;
    run(200);
    check_eq("t2_b_ready_again", s_b.tready, 1'b1);
    check_eq("t2_pair_count", pair_count, 2'd2);

    // Random downstream stalls over four pairs.
    rand_rdy = 1;
    add_pair(2, 5, 12);
    add_pair(3, 40, 7);
    add_pair(4, 9, 33);
    add_pair(5, 17, 5);
    run(3000);
    rand_rdy = 0;
    check_eq("t3_pair_count", pair_count, 2'd2);

    // Single-token trees.
    add_pair(6, 1, 1);
    run(100);
    check_eq("t4_pair_count", pair_count, 2'd3);

    // Reset after two of five A tokens have gone downstream.
    add_pair(7, 5, 2);
    for (int n = 0; n < 100 && exp_q.size() > 5; n++) step();
    check_eq("t5_two_sent", exp_q.size(), 5);
    apply_reset();
    repeat (5) step();
    check_eq("t5_flushed", m.tvalid, 1'b0);
    check_eq("t5_a_ready", s_a.tready, 1'b1);
    add_pair(8, 2, 2);
    run(100);
    check_eq("t5_count_restart", pair_count, 2'd1);

    // Counter wrap across five pairs: 1,2,3,0,1.
    apply_reset();
    for (int p = 0; p < 5; p++) add_pair(9 + p, 1, 1);
    run(200);
    check_eq("t6_wrapped_count", pair_count, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks want completion", checks);
    $fatal(1);
  end

endmodule
